softmax_result_streamer: RTL and testbench
==========================================

Name: softmax_result_streamer

Overview:
Downstream consumer of the N-lane softmax core. Captures the flat probability vector when the core's valid_out pulses and serialises it as one 16-bit Q6.10 element per cycle over a valid/ready stream, so probabilities can leave the datapath through a narrow port. A one-deep pending slot absorbs a second vector that arrives while the first is still streaming. Vectors that arrive when both slots are full are dropped and counted.

Parameters:
N, 64, number of lanes per softmax vector
W, 16, element width in bits (Q6.10)
IDX_W, 6, index width; must satisfy 2**IDX_W >= N

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous active-high reset
valid_in  input  1  single-cycle capture strobe; wired to softmax valid_out
prob_flat  input  N*W  probability vector; lane i = prob_flat[i*W +: W]
in_ready  output  1  high when pending slot empty (upstream may hold en low otherwise)
out_valid  output  1  out_data/out_idx/out_last valid
out_ready  input  1  downstream accept
out_data  output  W  current element
out_idx  output  IDX_W  lane index of out_data
out_last  output  1  high with lane N-1
drop_pulse  output  1  one-cycle pulse per dropped vector
drop_count  output  8  saturating count of dropped vectors
argmax_valid  output  1  one-cycle pulse after last element of each vector
argmax_idx  output  IDX_W  lowest index holding the maximum of the last finished vector
argmax_val  output  W  that maximum value

Behaviour:
- Reset (rst=1 on a clk edge) values: state IDLE, both slots empty, out_valid=0, out_idx=0, out_last=0, in_ready=1, drop_pulse=0, drop_count=0, argmax_valid=0, argmax_idx=0, argmax_val=0. Reset mid-stream discards both slots with no further output.
- Storage: active buffer N*W, pending buffer N*W, pending_full flag, lane counter IDX_W.
- Handshake: transfer = out_valid & out_ready. out_data, out_idx and out_last hold stable while out_valid=1 and out_ready=0. out_data = active[idx*W +: W], registered or muxed from registered state, with no combinational path from prob_flat.
- FSM states: IDLE and STREAM.
- IDLE with valid_in: load active, idx=0, go to STREAM. out_valid=1 the next cycle (1-cycle latency).
- STREAM with transfer and not last: idx+1.
- STREAM with transfer on idx=N-1 (last element):
  - pending_full: active<=pending, clear pending_full, idx=0, stay in STREAM. No bubble.
  - else valid_in in the same cycle: active<=prob_flat, idx=0, stay in STREAM.
  - else go to IDLE, out_valid=0.
- STREAM with valid_in, when not consumed by the last-element rule above:
  - pending empty: load pending, set pending_full.
  - pending full and no last transfer this cycle: drop the vector, drop_pulse=1, drop_count+1 (saturates at 255).
  - pending full and last transfer this cycle: pending moves to active and the new vector loads pending. Not a drop.
- in_ready = ~pending_full, registered.
- Element order is lane 0 first. out_last = (idx==N-1) & out_valid.

Optional Feature:
- Macro STREAMER_ARGMAX_EN.
- Defined: a running max/index is updated on every transfer, using an unsigned compare and strict greater-than, so ties keep the lowest index. The running register is reset to value 0, index 0 at the start of each vector.
- Defined, completion: the cycle after the last transfer, argmax_valid=1 for one cycle. argmax_idx/argmax_val update then and hold until the next completion.
- Not defined: argmax_valid, argmax_idx and argmax_val are tied to 0 and no compare logic is synthesised.

Test Plan:
- Single vector, lane i = i*16, out_ready=1 constant -> 64 consecutive beats idx 0..63, data 0..1008, out_last only on idx 63, out_valid low the following cycle.
- Backpressure: same vector, out_ready toggles 1,0,0,1,... -> no duplicated or skipped idx, and data stable while stalled.
- Back-to-back: vector A (all 0x0400), then vector B (all 0x0200) 5 cycles later -> 64 beats 0x0400 followed immediately by 64 beats 0x0200, no gap, in_ready low from B's capture until A's last beat.
- Overflow: A, B and C strobed at cycles 0, 2 and 4 with out_ready=0 -> drop_pulse once at C, drop_count=1. After releasing out_ready, only A then B stream.
- Boundary: pending full, valid_in coincides with A's last transfer -> B becomes active, new vector goes to pending, drop_count unchanged.
- Argmax (macro on): lanes 7 and 40 = 0x0300, all others 0x0010 -> argmax_valid pulse after beat 63, argmax_idx=7, argmax_val=0x0300. Reset asserted mid-stream -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/softmax_result_streamer.sv
// softmax_result_streamer: captures an N-lane probability vector on valid_in
// and serialises it one W-bit element per beat over a valid/ready stream.
// A one-deep pending slot absorbs a second vector; further vectors are
// dropped and counted. Optional argmax tracking under STREAMER_ARGMAX_EN.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_in, prob_flat      capture strobe and flat vector (lane i at i*W)
//   in_ready                 pending slot empty
//   out_valid/out_ready      output stream handshake
//   out_data/out_idx/out_last element, lane index, last-lane flag
//   drop_pulse/drop_count    dropped-vector pulse and saturating count
//   argmax_valid/idx/val     per-vector argmax result (zero when disabled)
module softmax_result_streamer #(
    parameter int N     = 64,
    parameter int W     = 16,
    parameter int IDX_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [N*W-1:0]     prob_flat,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last,
    output logic               drop_pulse,
    output logic [7:0]         drop_count,
    output logic               argmax_valid,
    output logic [IDX_W-1:0]   argmax_idx,
    output logic [W-1:0]       argmax_val
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state, state_n;
    logic [N*W-1:0]   active, pending;
    logic             pending_full, pending_full_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             xfer, last_xfer;
    logic             act_from_pend, act_from_in, pend_from_in, drop;

    assign out_valid = (state == STREAM);
    assign xfer      = out_valid & out_ready;
    assign last_xfer = xfer & (idx == LAST);
    assign out_data  = active[idx*W +: W];
    assign out_idx   = idx;
    assign out_last  = out_valid & (idx == LAST);
    assign in_ready  = ~pending_full;

    always_comb begin
        state_n        = state;
        idx_n          = idx;
        pending_full_n = pending_full;
        act_from_pend  = 1'b0;
        act_from_in    = 1'b0;
        pend_from_in   = 1'b0;
        drop           = 1'b0;
        unique case (state)
            IDLE: begin
                if (valid_in) begin
                    act_from_in = 1'b1;
                    idx_n       = '0;
                    state_n     = STREAM;
                end
            end
            STREAM: begin
                if (xfer) idx_n = idx + 1'b1;
                if (last_xfer) begin
                    // Refill straight from pending (or the incoming vector)
                    // so the next vector follows without a bubble.
                    idx_n = '0;
                    if (pending_full) begin
                        act_from_pend = 1'b1;
                        if (valid_in) pend_from_in = 1'b1;
                        else          pending_full_n = 1'b0;
                    end else if (valid_in) begin
                        act_from_in = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (valid_in) begin
                    if (!pending_full) begin
                        pend_from_in   = 1'b1;
                        pending_full_n = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending_full <= 1'b0;
            idx          <= '0;
            drop_pulse   <= 1'b0;
            drop_count   <= '0;
        end else begin
            state        <= state_n;
            pending_full <= pending_full_n;
            idx          <= idx_n;
            drop_pulse   <= drop;
            if (drop && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    // Data buffers carry no reset; their contents are qualified by state.
    always_ff @(posedge clk) begin
        if (act_from_pend)    active <= pending;
        else if (act_from_in) active <= prob_flat;
        if (pend_from_in)     pending <= prob_flat;
    end

`ifdef STREAMER_ARGMAX_EN
    logic [W-1:0]     run_val, base_val, best_val;
    logic [IDX_W-1:0] run_idx, base_idx, best_idx;

    // Lane 0 compares against a fresh zero, restarting the search per vector.
    always_comb begin
        base_val = (idx == '0) ? '0 : run_val;
        base_idx = (idx == '0) ? '0 : run_idx;
        best_val = base_val;
        best_idx = base_idx;
        if (out_data > base_val) begin
            best_val = out_data;
            best_idx = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_val      <= '0;
            run_idx      <= '0;
            argmax_valid <= 1'b0;
            argmax_idx   <= '0;
            argmax_val   <= '0;
        end else begin
            argmax_valid <= 1'b0;
            if (xfer) begin
                run_val <= best_val;
                run_idx <= best_idx;
            end
            if (last_xfer) begin
                argmax_valid <= 1'b1;
                argmax_idx   <= best_idx;
                argmax_val   <= best_val;
            end
        end
    end
`else
    assign argmax_valid = 1'b0;
    assign argmax_idx   = '0;
    assign argmax_val   = '0;
`endif

endmodule

// File: tb/tb_softmax_result_streamer.sv
// Testbench for softmax_result_streamer: queue-based reference model of the
// two-slot streamer checked every cycle, plus directed literal expectations.
module tb_softmax_result_streamer;

    localparam int N     = 64;
    localparam int W     = 16;
    localparam int IDX_W = 6;

    typedef logic [N*W-1:0] vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             valid_in = 1'b0;
    logic             out_ready = 1'b0;
    vec_t             prob_flat = '0;
    logic             in_ready, out_valid, out_last;
    logic [W-1:0]     out_data;
    logic [IDX_W-1:0] out_idx;
    logic             drop_pulse;
    logic [7:0]       drop_count;
    logic             argmax_valid;
    logic [IDX_W-1:0] argmax_idx;
    logic [W-1:0]     argmax_val;

    always #5 clk = ~clk;

    softmax_result_streamer #(.N(N), .W(W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .prob_flat(prob_flat),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .drop_pulse(drop_pulse), .drop_count(drop_count),
        .argmax_valid(argmax_valid), .argmax_idx(argmax_idx),
        .argmax_val(argmax_val)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: vectors held by the block, in arrival order.
    vec_t mq[$];
    int   mbeat = 0;
    int   mdrop_cnt = 0;
    bit   mdrop_p = 0;
    bit   marg_v = 0;
    int   marg_idx = 0;
    int   marg_val = 0;
    bit   model_live = 0;
    bit   m_xf;
    int   m_bi, m_bv;

    function automatic void argmax_of(input vec_t v, output int bi, output int bv);
        bi = 0;
        bv = 0;
        for (int i = 0; i < N; i++) begin
            if (int'(v[i*W +: W]) > bv) begin
                bv = int'(v[i*W +: W]);
                bi = i;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mbeat = 0; mdrop_cnt = 0; mdrop_p = 0;
            marg_v = 0; marg_idx = 0; marg_val = 0;
        end else begin
            mdrop_p = 0;
            marg_v  = 0;
            m_xf = (mq.size() > 0) && out_ready;
            if (m_xf) begin
                if (mbeat == N - 1) begin
                    argmax_of(mq[0], m_bi, m_bv);
                    marg_idx = m_bi;
                    marg_val = m_bv;
                    marg_v   = 1;
                    void'(mq.pop_front());
                    mbeat = 0;
                end else begin
                    mbeat++;
                end
            end
            if (valid_in) begin
                if (mq.size() < 2) mq.push_back(prob_flat);
                else begin
                    mdrop_p = 1;
                    if (mdrop_cnt < 255) mdrop_cnt++;
                end
            end
        end
        model_live = 1;
    end

    int   beat_cnt = 0;
    int   apulse = 0;
    logic [W-1:0] seen [N];
    vec_t cur;

    always @(negedge clk) begin
        if (model_live) begin
            chk("out_valid", out_valid, mq.size() > 0);
            chk("in_ready", in_ready, mq.size() < 2);
            chk("drop_pulse", drop_pulse, mdrop_p);
            chk("drop_count", drop_count, mdrop_cnt);
            chk("out_idx", out_idx, mbeat);
            chk("out_last", out_last, (mq.size() > 0) && (mbeat == N - 1));
            if (mq.size() > 0) begin
                cur = mq[0];
                chk("out_data", out_data, cur[mbeat*W +: W]);
            end
`ifdef STREAMER_ARGMAX_EN
            chk("argmax_valid", argmax_valid, marg_v);
            chk("argmax_idx", argmax_idx, marg_idx);
            chk("argmax_val", argmax_val, marg_val);
`else
            chk("argmax_valid", argmax_valid, 0);
            chk("argmax_idx", argmax_idx, 0);
            chk("argmax_val", argmax_val, 0);
`endif
            if (out_valid && out_ready) begin
                seen[out_idx] = out_data;
                beat_cnt++;
            end
            if (argmax_valid) apulse++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input vec_t v);
        prob_flat = v;
        valid_in  = 1'b1;
        tick();
        valid_in  = 1'b0;
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0 repeating; 2: never ready
    task automatic run(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            out_ready = (mode == 0) ? 1'b1 :
                        (mode == 1) ? 1'((c % 3) == 0) : 1'b0;
            tick();
        end
    endtask

    function automatic vec_t ramp();
        vec_t v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(i * 16);
        return v;
    endfunction

    function automatic vec_t fill(input logic [W-1:0] x);
        vec_t v;
        for (int i = 0; i < N; i++) v[i*W +: W] = x;
        return v;
    endfunction

    vec_t va, vb, vc;

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_argmax_idx", argmax_idx, 0);

        // Single ramp vector, always ready
        beat_cnt  = 0;
        out_ready = 1'b1;
        strobe(ramp());
        run(70, 0);
        chk("t1_beats", beat_cnt, 64);
        chk("t1_first", seen[0], 16'd0);
        chk("t1_lastdata", seen[63], 16'd1008);
        chk("t1_mid", seen[10], 16'd160);

        // Backpressure
        beat_cnt = 0;
        strobe(ramp());
        run(300, 1);
        chk("t2_beats", beat_cnt, 64);
        chk("t2_lastdata", seen[63], 16'd1008);

        // Back-to-back A then B five cycles later
        beat_cnt  = 0;
        out_ready = 1'b1;
        strobe(fill(16'h0400));
        run(4, 0);
        strobe(fill(16'h0200));
        run(140, 0);
        chk("t3_beats", beat_cnt, 128);
        chk("t3_tail", seen[63], 16'h0200);

        // Overflow: A, B, C at cycles 0, 2, 4 with no downstream acceptance
        beat_cnt  = 0;
        out_ready = 1'b0;
        strobe(fill(16'h0001));
        tick();
        strobe(fill(16'h0002));
        tick();
        strobe(fill(16'h0003));
        chk("t4_drop_pulse", drop_pulse, 1);
        tick();
        chk("t4_drop_count", drop_count, 1);
        run(150, 0);
        chk("t4_beats", beat_cnt, 128);
        chk("t4_tail", seen[63], 16'h0002);

        // Boundary: new vector coincides with A's last transfer
        beat_cnt = 0;
        va = fill(16'h0011);
        vb = fill(16'h0022);
        vc = ramp();
        out_ready = 1'b1;
        for (int c = 0; c < 210; c++) begin
            valid_in  = (c == 0) || (c == 2) || (c == 64);
            prob_flat = (c == 0) ? va : (c == 2) ? vb : vc;
            tick();
        end
        valid_in = 1'b0;
        chk("t5_drop_count", drop_count, 1);
        chk("t5_beats", beat_cnt, 192);
        chk("t5_tail", seen[63], 16'd1008);

        // Argmax vector with a tie on lanes 7 and 40
        apulse = 0;
        va = fill(16'h0010);
        va[7*W +: W]  = 16'h0300;
        va[40*W +: W] = 16'h0300;
        strobe(va);
        run(70, 0);
`ifdef STREAMER_ARGMAX_EN
        chk("t6_pulses", apulse, 1);
        chk("t6_idx", argmax_idx, 7);
        chk("t6_val", argmax_val, 16'h0300);
`else
        chk("t6_pulses", apulse, 0);
        chk("t6_val", argmax_val, 0);
`endif

        // Reset mid-stream
        strobe(ramp());
        run(10, 0);
        rst = 1'b1;
        tick();
        chk("t7_out_valid", out_valid, 0);
        chk("t7_out_idx", out_idx, 0);
        chk("t7_in_ready", in_ready, 1);
        chk("t7_drop_count", drop_count, 0);
        chk("t7_argmax_val", argmax_val, 0);
        rst = 1'b0;
        run(5, 0);
        chk("t7_quiet", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
